// File: rtl/lab1_imul_pkg.sv
// Shared types and helpers for the variable-latency iterative multiplier.
// Operation encoding follows the RISC-V M-extension multiply family.
package lab1_imul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic op_signed_a(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic op_signed_b(input op_e op);
    return (op == OP_MULH);
  endfunction

endpackage

// File: rtl/lab1_imul_ctz.sv
// Combinational trailing-zero counter; the count saturates to NBITS when b is zero.
module lab1_imul_ctz #(
  parameter int NBITS = 32
) (
  input  logic [NBITS-1:0]               b,
  output logic                           is_zero,
  output logic [$clog2(NBITS+1)-1:0]     count
);

  localparam int CW = $clog2(NBITS + 1);

  logic [CW-1:0] count_s;

  // Scan from the MSB down so the lowest set bit wins.
  always_comb begin
    count_s = CW'(NBITS);
    for (int i = NBITS - 1; i >= 0; i--) begin
      count_s = b[i] ? CW'(i) : count_s;
    end
  end

  assign is_zero = (b == {NBITS{1'b0}});
  assign count   = count_s;

endmodule

// File: rtl/vc_SimpleAdder.sv
// Plain modular adder used for the multiplier accumulate.
module vc_SimpleAdder #(
  parameter int p_nbits = 1
) (
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  output logic [p_nbits-1:0] out
);

  assign out = in0 + in1;

endmodule

// File: rtl/lab1_imul_int_mul_var.sv
// Variable-latency zero-skipping multiplier supporting MUL/MULH/MULHSU/MULHU
// behind val/rdy request and response streams.
module lab1_imul_int_mul_var
  import lab1_imul_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int MAX_SKIP = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [2*NBITS+1:0]   istream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [NBITS-1:0]     ostream_msg
);

  localparam int W2 = 2 * NBITS;
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW:0] MAX_SKIP_C = (CW + 1)'(MAX_SKIP);

  state_e             state_r, state_n;
  op_e                op_r;
  logic               neg_r;
  logic [W2-1:0]      a_r;
  logic [NBITS-1:0]   b_r;
  logic [W2-1:0]      acc_r;
  logic [NBITS-1:0]   msg_r;
  logic               oval_r;
  logic               irdy_r;

  logic [1:0]         in_op_s;
  logic [NBITS-1:0]   in_a_s, in_b_s;
  logic               sa_s, sb_s;
  logic [NBITS-1:0]   a_mag_s, b_mag_s;
  logic               accept_s;

  logic               b_zero_s, a_zero_s, done_s, take_s;
  logic [CW-1:0]      tz_s;
  logic [CW:0]        sh_s;
  logic [W2-1:0]      addend_s, sum_s, fix_s;
  logic [NBITS-1:0]   res_s;

  assign {in_op_s, in_a_s, in_b_s} = istream_msg;
  assign sa_s     = op_signed_a(op_e'(in_op_s));
  assign sb_s     = op_signed_b(op_e'(in_op_s));
  // The most-negative value negates to itself, which reads back as 2^(NBITS-1) unsigned.
  assign a_mag_s  = (sa_s && in_a_s[NBITS-1]) ? -in_a_s : in_a_s;
  assign b_mag_s  = (sb_s && in_b_s[NBITS-1]) ? -in_b_s : in_b_s;
  assign accept_s = istream_val && irdy_r;

  lab1_imul_ctz #(.NBITS(NBITS)) u_ctz (
    .b       (b_r),
    .is_zero (b_zero_s),
    .count   (tz_s)
  );

  assign a_zero_s = (a_r == {W2{1'b0}});
  assign done_s   = b_zero_s || a_zero_s;
  assign take_s   = ({1'b0, tz_s} < MAX_SKIP_C);
  assign sh_s     = take_s ? ({1'b0, tz_s} + (CW + 1)'(1)) : MAX_SKIP_C;
  assign addend_s = take_s ? (a_r << tz_s) : {W2{1'b0}};

  vc_SimpleAdder #(.p_nbits(W2)) u_add (
    .in0 (acc_r),
    .in1 (addend_s),
    .out (sum_s)
  );

  assign fix_s = neg_r ? -acc_r : acc_r;
  assign res_s = (op_r == OP_MUL) ? fix_s[NBITS-1:0] : fix_s[W2-1:NBITS];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_n = IDLE;
    case (state_r)
      IDLE:    if (accept_s)    state_n = CALC; else state_n = IDLE;
      CALC:    if (done_s)      state_n = DONE; else state_n = CALC;
      DONE:    if (ostream_rdy) state_n = IDLE; else state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r   <= OP_MUL;
      neg_r  <= 1'b0;
      a_r    <= {W2{1'b0}};
      b_r    <= {NBITS{1'b0}};
      acc_r  <= {W2{1'b0}};
      msg_r  <= {NBITS{1'b0}};
      oval_r <= 1'b0;
      irdy_r <= 1'b0;
    end else begin
      oval_r <= (state_n == DONE);
      irdy_r <= (state_n == IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r  <= op_e'(in_op_s);
            neg_r <= (sa_s && in_a_s[NBITS-1]) ^ (sb_s && in_b_s[NBITS-1]);
            a_r   <= {{NBITS{1'b0}}, a_mag_s};
            b_r   <= b_mag_s;
            acc_r <= {W2{1'b0}};
          end
        end
        CALC: begin
          if (done_s) begin
            msg_r <= res_s;
          end else begin
            acc_r <= sum_s;
            a_r   <= a_r << sh_s;
            b_r   <= b_r >> sh_s;
          end
        end
        default: begin
          msg_r <= msg_r;
        end
      endcase
    end
  end

  assign istream_rdy = irdy_r;
  assign ostream_val = oval_r;
  assign ostream_msg = msg_r;

endmodule
